// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state type and element helpers for acc_unit stage wrappers
package acc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_LAUNCH,
    S_WAIT,
    S_SCATTER
  } acc_state_e;

  // Widen the low w bits of v to 64 bits, replicating bit w-1 when sext is set.
  function automatic logic [63:0] elem_extend(input logic [63:0] v, input int w, input bit sext);
    logic [63:0] mask;
    logic [63:0] res;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    res  = v & mask;
    if (sext && (w < 64) && ((v & (64'd1 << (w - 1))) != 64'd0))
      res = res | ~mask;
    return res;
  endfunction

endpackage

// File: rtl/acc_elem_serializer.sv
// rtl/acc_elem_serializer.sv - parallel-load element register with 64-bit head element
module acc_elem_serializer
  import acc_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int SIGN_EXT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [N*W-1:0] load_data,
  input  logic           step,
  input  logic [W-1:0]   step_in,
  output logic [N*W-1:0] vec,
  output logic [63:0]    head
);

  // Stepping drops element 0 and enters step_in at the top, so the same register
  // drains a block element by element or fills one in arrival order.
  always_ff @(posedge clk) begin
    if (rst)
      vec <= '0;
    else if (load)
      vec <= load_data;
    else if (step)
      vec <= {step_in, vec[N*W-1:W]};
  end

  assign head = elem_extend(64'(vec[W-1:0]), W, SIGN_EXT != 0);

endmodule

// File: rtl/acc_stage_stream_wrapper.sv
// rtl/acc_stage_stream_wrapper.sv - framing wrapper feeding one block at a time to a compute core
module acc_stage_stream_wrapper
  import acc_pkg::*;
#(
  parameter int NUM_IN   = 128,
  parameter int NUM_OUT  = 128,
  parameter int ELEM_W   = 32,
  parameter int SIGN_EXT = 0,
  parameter int TIMEOUT  = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_src_fwd,
  input  logic                      cfg_dst_fwd,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [63:0]               in_data,
  input  logic                      fwd_in_valid,
  input  logic [NUM_IN*ELEM_W-1:0]  fwd_in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [63:0]               out_data,
  output logic                      fwd_out_valid,
  input  logic                      fwd_out_ready,
  output logic [NUM_OUT*ELEM_W-1:0] fwd_out_data,
  output logic                      core_i_valid,
  input  logic                      core_i_ready,
  output logic [NUM_IN*ELEM_W-1:0]  core_i_data,
  input  logic                      core_o_valid,
  output logic                      core_o_ready,
  input  logic [NUM_OUT*ELEM_W-1:0] core_o_data,
  output logic                      busy,
  output logic [31:0]               blocks_done,
  output logic                      timeout_err
);

  localparam int IDX_W  = $clog2((NUM_IN > NUM_OUT) ? NUM_IN : NUM_OUT);
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(NUM_IN - 1);
  localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(NUM_OUT - 1);

  acc_state_e state, state_nxt;
  logic              src_fwd, dst_fwd;
  logic [IDX_W-1:0]  idx;
  logic [WCNT_W-1:0] wcnt;
  logic              start, fwd_cap, core_cap, timeout_hit, done;
  logic              in_hs, out_hs;

  logic [NUM_IN*ELEM_W-1:0]  gather_vec;
  logic [NUM_OUT*ELEM_W-1:0] result_vec;
  logic [63:0]               gather_head, scatter_head;
  logic                      unused_bits;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    core_i_valid  = 1'b0;
    core_o_ready  = 1'b0;
    out_valid     = 1'b0;
    fwd_out_valid = 1'b0;
    start         = 1'b0;
    fwd_cap       = 1'b0;
    core_cap      = 1'b0;
    timeout_hit   = 1'b0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        if ((!cfg_src_fwd && in_valid) || (cfg_src_fwd && fwd_in_valid)) begin
          start     = 1'b1;
          state_nxt = S_GATHER;
        end
      end
      S_GATHER: begin
        if (src_fwd) begin
          fwd_cap   = 1'b1;
          state_nxt = S_LAUNCH;
        end else begin
          in_ready = 1'b1;
          if (in_valid && idx == LAST_IN)
            state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_i_valid = 1'b1;
        if (core_i_ready)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        core_o_ready = 1'b1;
        if (core_o_valid) begin
          core_cap  = 1'b1;
          state_nxt = S_SCATTER;
        end else if (TIMEOUT > 0 && wcnt == WCNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_SCATTER: begin
        if (dst_fwd) begin
          fwd_out_valid = 1'b1;
          if (fwd_out_ready) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          out_valid = 1'b1;
          if (out_ready && idx == LAST_OUT) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      src_fwd     <= 1'b0;
      dst_fwd     <= 1'b0;
      idx         <= '0;
      wcnt        <= '0;
      blocks_done <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        src_fwd <= cfg_src_fwd;
        dst_fwd <= cfg_dst_fwd;
        idx     <= '0;
      end else if (core_cap) begin
        idx <= '0;
      end else if (in_hs || out_hs) begin
        idx <= idx + IDX_W'(1);
      end
      // The wait counter restarts on every launch cycle, so it only measures core silence.
      if (state == S_LAUNCH)
        wcnt <= '0;
      else if (state == S_WAIT)
        wcnt <= wcnt + WCNT_W'(1);
      if (timeout_hit)
        timeout_err <= 1'b1;
      if (done)
        blocks_done <= blocks_done + 32'd1;
    end
  end

  acc_elem_serializer #(
    .N(NUM_IN), .W(ELEM_W), .SIGN_EXT(0)
  ) u_gather (
    .clk       (clk),
    .rst       (rst),
    .load      (fwd_cap),
    .load_data (fwd_in_data),
    .step      (in_hs),
    .step_in   (in_data[ELEM_W-1:0]),
    .vec       (gather_vec),
    .head      (gather_head)
  );

  acc_elem_serializer #(
    .N(NUM_OUT), .W(ELEM_W), .SIGN_EXT(SIGN_EXT)
  ) u_scatter (
    .clk       (clk),
    .rst       (rst),
    .load      (core_cap),
    .load_data (core_o_data),
    .step      (out_hs),
    .step_in   ('0),
    .vec       (result_vec),
    .head      (scatter_head)
  );

  assign busy         = (state != S_IDLE);
  assign core_i_data  = (state == S_LAUNCH) ? gather_vec : '0;
  assign out_data     = (state == S_SCATTER && !dst_fwd) ? scatter_head : 64'd0;
  assign fwd_out_data = (state == S_SCATTER && dst_fwd) ? result_vec : '0;
  assign unused_bits  = ^{gather_head, in_data};

endmodule

// File: tb/tb_acc_stage_stream_wrapper.sv
// tb/tb_acc_stage_stream_wrapper.sv - self-checking bench for acc_stage_stream_wrapper
module tb_acc_stage_stream_wrapper;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_src_fwd, cfg_dst_fwd;
  logic         in_valid, in_ready;
  logic [63:0]  in_data;
  logic         fwd_in_valid;
  logic [127:0] fwd_in_data;
  logic         out_valid, out_ready;
  logic [63:0]  out_data;
  logic         fwd_out_valid, fwd_out_ready;
  logic [127:0] fwd_out_data;
  logic         core_i_valid, core_i_ready;
  logic [127:0] core_i_data;
  logic         core_o_valid, core_o_ready;
  logic [127:0] core_o_data;
  logic         busy;
  logic [31:0]  blocks_done;
  logic         timeout_err;

  logic         zx_in_ready, zx_out_valid, zx_fwd_out_valid, zx_core_i_valid, zx_core_o_ready;
  logic         zx_busy, zx_timeout_err;
  logic [63:0]  zx_out_data;
  logic [127:0] zx_fwd_out_data, zx_core_i_data;
  logic [31:0]  zx_blocks_done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic rand_rdy = 1'b0, rand_gap = 1'b0, core_en = 1'b1, fwd_mode = 1'b0;
  logic core_rdy;

  logic [63:0]  exp_q[$];
  logic [63:0]  zx_q[$];
  logic [127:0] ci_q[$];

  always #5 clk = ~clk;

  acc_stage_stream_wrapper #(
    .NUM_IN(4), .NUM_OUT(4), .ELEM_W(32), .SIGN_EXT(1), .TIMEOUT(16)
  ) u_dut (
    .clk(clk), .rst(rst), .cfg_src_fwd(cfg_src_fwd), .cfg_dst_fwd(cfg_dst_fwd),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fwd_in_valid(fwd_in_valid), .fwd_in_data(fwd_in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fwd_out_valid(fwd_out_valid), .fwd_out_ready(fwd_out_ready), .fwd_out_data(fwd_out_data),
    .core_i_valid(core_i_valid), .core_i_ready(core_i_ready), .core_i_data(core_i_data),
    .core_o_valid(core_o_valid), .core_o_ready(core_o_ready), .core_o_data(core_o_data),
    .busy(busy), .blocks_done(blocks_done), .timeout_err(timeout_err)
  );

  // Zero-extending twin with the timeout disabled, driven by the same stimulus.
  acc_stage_stream_wrapper #(
    .NUM_IN(4), .NUM_OUT(4), .ELEM_W(32), .SIGN_EXT(0), .TIMEOUT(0)
  ) u_zx (
    .clk(clk), .rst(rst), .cfg_src_fwd(cfg_src_fwd), .cfg_dst_fwd(cfg_dst_fwd),
    .in_valid(in_valid), .in_ready(zx_in_ready), .in_data(in_data),
    .fwd_in_valid(fwd_in_valid), .fwd_in_data(fwd_in_data),
    .out_valid(zx_out_valid), .out_ready(out_ready), .out_data(zx_out_data),
    .fwd_out_valid(zx_fwd_out_valid), .fwd_out_ready(fwd_out_ready), .fwd_out_data(zx_fwd_out_data),
    .core_i_valid(zx_core_i_valid), .core_i_ready(core_i_ready), .core_i_data(zx_core_i_data),
    .core_o_valid(core_o_valid), .core_o_ready(zx_core_o_ready), .core_o_data(core_o_data),
    .busy(zx_busy), .blocks_done(zx_blocks_done), .timeout_err(zx_timeout_err)
  );

  // Loopback core: answers 3 cycles after accepting a block, unless core_en is low.
  logic [127:0] core_buf;
  logic         core_pend;
  int           core_cnt;
  assign core_i_ready = core_rdy;
  assign core_o_data  = core_buf;

  always @(posedge clk) begin
    if (rst) begin
      core_o_valid <= 1'b0;
      core_pend    <= 1'b0;
      core_cnt     <= 0;
      core_buf     <= '0;
    end else begin
      if (core_i_valid && core_i_ready) begin
        core_buf  <= core_i_data;
        core_pend <= core_en;
        core_cnt  <= 0;
      end else if (core_pend) begin
        if (core_cnt == 2) begin
          core_o_valid <= 1'b1;
          core_pend    <= 1'b0;
        end else begin
          core_cnt <= core_cnt + 1;
        end
      end
      if (core_o_valid && core_o_ready)
        core_o_valid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    core_rdy  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [63:0] ref_ext(input logic [63:0] d, input bit sx);
    return sx ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
  endfunction

  // Monitor: output order/content, stall stability, idle and forward-mode rules.
  logic         prev_ov = 1'b0, prev_or = 1'b0, prev_civ = 1'b0, prev_cir = 1'b0;
  logic [63:0]  prev_od = '0;
  logic [127:0] prev_cid = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_ov  = 1'b0;
      prev_civ = 1'b0;
    end else begin
      if (out_valid && prev_ov && !prev_or) chk("out_hold", out_data, prev_od);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) bound_fail("out_unexpected");
        else chk("out_data", out_data, exp_q.pop_front());
      end
      if (zx_out_valid && out_ready) begin
        if (zx_q.size() == 0) bound_fail("zx_out_unexpected");
        else chk("zx_out_data", zx_out_data, zx_q.pop_front());
      end
      if (core_i_valid && prev_civ && !prev_cir) chk("core_i_hold", core_i_data, prev_cid);
      if (core_i_valid && core_i_ready) begin
        if (ci_q.size() == 0) bound_fail("core_i_unexpected");
        else chk("core_i_data", core_i_data, ci_q.pop_front());
      end
      if (!busy) chk("idle_in_ready", in_ready, 1'b0);
      if (fwd_mode) begin
        chk("fwd_in_ready", in_ready, 1'b0);
        chk("fwd_no_stream_out", out_valid, 1'b0);
      end
      prev_ov  = out_valid;
      prev_or  = out_ready;
      prev_od  = out_data;
      prev_civ = core_i_valid;
      prev_cir = core_i_ready;
      prev_cid = core_i_data;
    end
  end

  task automatic send_beat(input logic [63:0] d);
    int n;
    if (rand_gap)
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        @(posedge clk); #1;
      end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) bound_fail("in_beat");
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic send_block(input logic [3:0][63:0] din, input logic [3:0][63:0] esx,
                            input logic [3:0][63:0] ezx);
    logic [127:0] ci;
    for (int k = 0; k < 4; k++) begin
      ci[k*32 +: 32] = din[k][31:0];
      exp_q.push_back(esx[k]);
      zx_q.push_back(ezx[k]);
    end
    ci_q.push_back(ci);
    for (int k = 0; k < 4; k++) send_beat(din[k]);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    @(negedge clk);
    while (blocks_done != 32'(target) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("blocks_done", blocks_done, 128'(target));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0][63:0] din;
    logic [3:0][63:0] exp_sx;
    logic [3:0][63:0] exp_zx;
  } vec_t;

  vec_t tbl[3];

  initial begin
    logic [3:0][63:0] rd, rsx, rzx;
    int n;

    rst = 1'b1; cfg_src_fwd = 1'b0; cfg_dst_fwd = 1'b0;
    in_valid = 1'b0; in_data = '0; fwd_in_valid = 1'b0; fwd_in_data = '0; fwd_out_ready = 1'b0;

    tbl[0].din    = {64'hFFFF_FFFF_0000_0004, 64'h3, 64'h2, 64'h1};
    tbl[0].exp_sx = {64'h4, 64'h3, 64'h2, 64'h1};
    tbl[0].exp_zx = {64'h4, 64'h3, 64'h2, 64'h1};
    tbl[1].din    = {64'hABCD_0000_1234_5678, 64'hFFFF_FFFF, 64'h7FFF_FFFF, 64'h8000_0000};
    tbl[1].exp_sx = {64'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0000};
    tbl[1].exp_zx = {64'h1234_5678, 64'hFFFF_FFFF, 64'h7FFF_FFFF, 64'h8000_0000};
    tbl[2].din    = {64'h5A5A_5A5A, 64'h1_0000_0000, 64'hDEAD_BEEF, 64'h0};
    tbl[2].exp_sx = {64'h5A5A_5A5A, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 64'h0};
    tbl[2].exp_zx = {64'h5A5A_5A5A, 64'h0, 64'hDEAD_BEEF, 64'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_fwd_out_valid", fwd_out_valid, 1'b0);
    chk("rst_fwd_out_data", fwd_out_data, 128'd0);
    chk("rst_core_i_valid", core_i_valid, 1'b0);
    chk("rst_core_i_data", core_i_data, 128'd0);
    chk("rst_core_o_ready", core_o_ready, 1'b0);
    chk("rst_blocks_done", blocks_done, 32'd0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_zx_outputs", {zx_in_ready, zx_out_valid, zx_fwd_out_valid, zx_core_i_valid,
                           zx_core_o_ready, zx_busy, zx_timeout_err}, 7'd0);
    chk("rst_zx_data", zx_fwd_out_data | zx_core_i_data | 128'(zx_out_data) | 128'(zx_blocks_done), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      send_block(tbl[i].din, tbl[i].exp_sx, tbl[i].exp_zx);
      wait_done(i + 1);
    end

    rand_gap = 1'b1;
    rand_rdy = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 4; k++) begin
        rd[k]  = {$urandom, $urandom};
        rsx[k] = ref_ext(rd[k], 1'b1);
        rzx[k] = ref_ext(rd[k], 1'b0);
      end
      send_block(rd, rsx, rzx);
    end
    wait_done(9);
    rand_gap = 1'b0;
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Forward in/out, with a destination flip mid-block that must be ignored.
    cfg_src_fwd = 1'b1;
    cfg_dst_fwd = 1'b1;
    fwd_in_data = {32'd4, 32'd3, 32'd2, 32'd1};
    ci_q.push_back(fwd_in_data);
    fwd_mode     = 1'b1;
    fwd_in_valid = 1'b1;
    @(posedge clk); #1;
    fwd_in_valid = 1'b0;
    cfg_dst_fwd  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!fwd_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!fwd_out_valid) bound_fail("fwd_out_wait");
    for (int k = 0; k < 5; k++) begin
      chk("fwd_stall_valid", fwd_out_valid, 1'b1);
      chk("fwd_stall_data", fwd_out_data, {32'd4, 32'd3, 32'd2, 32'd1});
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    fwd_out_ready = 1'b1;
    @(negedge clk);
    chk("fwd_hs_valid", fwd_out_valid, 1'b1);
    @(posedge clk); #1;
    fwd_out_ready = 1'b0;
    @(negedge clk);
    chk("fwd_after_valid", fwd_out_valid, 1'b0);
    chk("fwd_after_data", fwd_out_data, 128'd0);
    chk("fwd_blocks_done", blocks_done, 32'd10);
    fwd_mode    = 1'b0;
    cfg_src_fwd = 1'b0;
    @(posedge clk); #1;

    // Silent core: timeout on the 16th wait cycle, no output, then a normal block.
    core_en = 1'b0;
    rd = {64'h44, 64'h33, 64'h22, 64'h11};
    ci_q.push_back({32'h44, 32'h33, 32'h22, 32'h11});
    for (int k = 0; k < 4; k++) send_beat(rd[k]);
    n = 0;
    @(negedge clk);
    while (!(core_i_valid && core_i_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(core_i_valid && core_i_ready)) bound_fail("timeout_launch");
    for (int k = 1; k <= 16; k++) @(negedge clk);
    chk("to_16_busy", busy, 1'b1);
    chk("to_16_core_o_ready", core_o_ready, 1'b1);
    chk("to_16_err", timeout_err, 1'b0);
    @(negedge clk);
    chk("to_17_err", timeout_err, 1'b1);
    chk("to_17_busy", busy, 1'b0);
    chk("to_blocks_done", blocks_done, 32'd10);
    chk("zx_no_timeout", {zx_busy, zx_timeout_err}, 2'b10);
    core_en = 1'b1;
    @(posedge clk); #1;
    send_block(tbl[1].din, tbl[1].exp_sx, tbl[1].exp_zx);
    wait_done(11);
    chk("to_err_sticky", timeout_err, 1'b1);

    // Reset after two of four beats discards the partial block.
    send_beat(64'hAA);
    send_beat(64'hBB);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_err", timeout_err, 1'b0);
    chk("mid_rst_blocks", blocks_done, 32'd0);
    @(posedge clk); #1;
    send_block(tbl[2].din, tbl[2].exp_sx, tbl[2].exp_zx);
    wait_done(1);

    repeat (4) @(posedge clk);
    chk("exp_q_drained", 128'(exp_q.size()), 128'd0);
    chk("zx_q_drained", 128'(zx_q.size()), 128'd0);
    chk("ci_q_drained", 128'(ci_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
